// File: rtl/fft_mag_writer.sv
// fft_mag_writer
//
// Writer side of the spectrum buffer. It accepts a streamed FFT output, one
// complex bin per beat, and computes the approximate magnitude
// max(|re|,|im|) + min(|re|,|im|)/2 for each bin. The first NBINS magnitudes
// of each frame are written into the spectrum RAM at address = bin index.
// The block also reports the peak bin of each good frame and flags malformed
// frames.
//
// State | meaning
// ------+---------------------------------------------------------------
// SYNC  | waiting for frame alignment; beats are discarded until s_last
// RUN   | aligned; every accepted beat enters the magnitude pipeline
//
// Ports:
//   clk, rst               system clock (also RAM write clock), sync active-high reset
//   s_valid/s_ready        input handshake; s_ready is 1 from the cycle after reset
//   s_re, s_im, s_last     signed bin components, end-of-frame marker
//   waddr, wdata, we       spectrum RAM write port (3 cycles after the beat)
//   frame_done, frame_err  one-cycle pulses for a good / malformed frame
//   peak_bin, peak_mag     largest bin (1..NBINS-1) of the last good frame

module fft_mag_writer #(
    parameter int FRAME_LEN = 2048,
    parameter int NBINS     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_re,
    input  logic [15:0] s_im,
    input  logic        s_last,
    output logic [10:0] waddr,
    output logic [15:0] wdata,
    output logic        we,
    output logic        frame_done,
    output logic        frame_err,
    output logic [10:0] peak_bin,
    output logic [15:0] peak_mag
);

    localparam logic [10:0] LAST_IDX = 11'(FRAME_LEN - 1);
    localparam logic [11:0] NBINS_W  = 12'(NBINS);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        s_ready_q, s_ready_d;
    logic [10:0] cnt_q, cnt_d;
    logic        ovr_q, ovr_d;

    // stage 1: absolute values
    logic        s1_vld_q, s1_vld_d;
    logic [10:0] s1_cnt_q, s1_cnt_d;
    logic        s1_last_q, s1_last_d;
    logic        s1_good_q, s1_good_d;
    logic [15:0] s1_a_q, s1_a_d;
    logic [15:0] s1_b_q, s1_b_d;

    // stage 2: max and halved min
    logic        s2_vld_q, s2_vld_d;
    logic [10:0] s2_cnt_q, s2_cnt_d;
    logic        s2_last_q, s2_last_d;
    logic        s2_good_q, s2_good_d;
    logic [15:0] s2_mx_q, s2_mx_d;
    logic [14:0] s2_mnh_q, s2_mnh_d;

    // stage 3: registered outputs and peak tracking
    logic        we_q, we_d;
    logic [10:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [10:0] peak_bin_q, peak_bin_d;
    logic [15:0] peak_mag_q, peak_mag_d;
    logic [10:0] run_bin_q, run_bin_d;
    logic [15:0] run_mag_q, run_mag_d;

    logic        accept;
    logic [15:0] mag;
    logic        in_range;
    logic [10:0] cand_bin;
    logic [15:0] cand_mag;

    always_comb begin
        state_d    = state_q;
        s_ready_d  = 1'b1;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;

        s1_vld_d   = 1'b0;
        s1_cnt_d   = s1_cnt_q;
        s1_last_d  = s1_last_q;
        s1_good_d  = s1_good_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;

        s2_vld_d   = s1_vld_q;
        s2_cnt_d   = s2_cnt_q;
        s2_last_d  = s2_last_q;
        s2_good_d  = s2_good_q;
        s2_mx_d    = s2_mx_q;
        s2_mnh_d   = s2_mnh_q;

        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        run_bin_d  = run_bin_q;
        run_mag_d  = run_mag_q;

        accept = s_valid & s_ready_q;

        // input stage: framing and bin counting
        case (state_q)
            SYNC: begin
                if (accept && s_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    s1_vld_d  = 1'b1;
                    s1_cnt_d  = cnt_q;
                    s1_last_d = s_last;
                    s1_good_d = s_last && (cnt_q == LAST_IDX) && !ovr_q;
                    // two's-complement negate maps -32768 to 0x8000 = 32768 unsigned
                    s1_a_d    = s_re[15] ? (~s_re + 16'd1) : s_re;
                    s1_b_d    = s_im[15] ? (~s_im + 16'd1) : s_im;
                    if (s_last) begin
                        cnt_d = 11'd0;
                        ovr_d = 1'b0;
                    end else if (cnt_q == LAST_IDX) begin
                        // missed s_last: wrap and remember the frame is bad
                        cnt_d = 11'd0;
                        ovr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        // stage 2
        if (s1_vld_q) begin
            s2_cnt_d  = s1_cnt_q;
            s2_last_d = s1_last_q;
            s2_good_d = s1_good_q;
            if (s1_a_q >= s1_b_q) begin
                s2_mx_d  = s1_a_q;
                s2_mnh_d = s1_b_q[15:1];
            end else begin
                s2_mx_d  = s1_b_q;
                s2_mnh_d = s1_a_q[15:1];
            end
        end

        // stage 3: max is 32768 + 16384, so a 16-bit sum never overflows
        mag      = s2_mx_q + {1'b0, s2_mnh_q};
        in_range = ({1'b0, s2_cnt_q} < NBINS_W);

        // strict compare keeps the earliest bin on ties; DC bin excluded
        cand_bin = run_bin_q;
        cand_mag = run_mag_q;
        if (s2_vld_q && in_range && (s2_cnt_q != 11'd0) && (mag > run_mag_q)) begin
            cand_bin = s2_cnt_q;
            cand_mag = mag;
        end

        if (s2_vld_q) begin
            if (in_range) begin
                we_d    = 1'b1;
                waddr_d = s2_cnt_q;
                wdata_d = mag;
            end
            if (s2_last_q) begin
                run_bin_d = 11'd0;
                run_mag_d = 16'd0;
                if (s2_good_q) begin
                    done_d     = 1'b1;
                    peak_bin_d = cand_bin;
                    peak_mag_d = cand_mag;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                run_bin_d = cand_bin;
                run_mag_d = cand_mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SYNC;
            s_ready_q  <= 1'b0;
            cnt_q      <= 11'd0;
            ovr_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_cnt_q   <= 11'd0;
            s1_last_q  <= 1'b0;
            s1_good_q  <= 1'b0;
            s1_a_q     <= 16'd0;
            s1_b_q     <= 16'd0;
            s2_vld_q   <= 1'b0;
            s2_cnt_q   <= 11'd0;
            s2_last_q  <= 1'b0;
            s2_good_q  <= 1'b0;
            s2_mx_q    <= 16'd0;
            s2_mnh_q   <= 15'd0;
            we_q       <= 1'b0;
            waddr_q    <= 11'd0;
            wdata_q    <= 16'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            peak_bin_q <= 11'd0;
            peak_mag_q <= 16'd0;
            run_bin_q  <= 11'd0;
            run_mag_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            s1_vld_q   <= s1_vld_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_last_q  <= s1_last_d;
            s1_good_q  <= s1_good_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_vld_q   <= s2_vld_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_last_q  <= s2_last_d;
            s2_good_q  <= s2_good_d;
            s2_mx_q    <= s2_mx_d;
            s2_mnh_q   <= s2_mnh_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
            run_bin_q  <= run_bin_d;
            run_mag_q  <= run_mag_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;

endmodule

// File: doc/fft_mag_writer.md
# fft_mag_writer

Writer side of the spectrum buffer consumed by the histogram display. It accepts a streamed FFT output, one complex bin per beat. For each bin it computes an approximate magnitude, then writes the first `NBINS` magnitudes into the dual-port spectrum RAM at address = bin index. It also reports the per-frame peak bin for the note detector and flags malformed frames.

## Interface

Parameters:
- `FRAME_LEN`, default 2048: FFT points per frame. Power of two, ≤ 2048.
- `NBINS`, default 1024: bins written per frame, indices 0..NBINS-1. Must satisfy NBINS ≤ FRAME_LEN.

Ports:
- `clk` in 1: system clock. Also the RAM write-port clock.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: block accepts beats.
- `s_re` in 16: bin real part, signed two's complement.
- `s_im` in 16: bin imaginary part, signed two's complement.
- `s_last` in 1: marks the final beat of an FFT frame.
- `waddr` out 11: spectrum RAM write address.
- `wdata` out 16: unsigned magnitude.
- `we` out 1: RAM write enable, one cycle per write.
- `frame_done` out 1: one-cycle pulse after a complete, well-formed frame.
- `frame_err` out 1: one-cycle pulse when `s_last` arrives at the wrong bin count.
- `peak_bin` out 11: index of the largest magnitude in the last good frame.
- `peak_mag` out 16: that magnitude.

## Operation

- A beat is accepted when `s_valid & s_ready`.
- `s_ready` is registered. It is 0 during `rst` and 1 from the first cycle after `rst` deasserts. No backpressure is applied after that.
- States:
  - SYNC (reset state): accepted beats are discarded, with no `we`. An accepted beat with `s_last` moves the state to RUN; that beat is itself discarded.
  - RUN: accepted beats are processed as described below.
- Bin counter `cnt` (11 bits):
  - Reset value 0.
  - Increments on each beat accepted in RUN.
  - Returns to 0 on an accepted `s_last` beat.
- Magnitude pipeline, in RUN, three stages:
  1. Take the absolute value of each component into 16-bit unsigned. abs(-32768) = 32768.
  2. Compute mx = max(a,b) and mn = min(a,b).
  3. Compute mag = mx + (mn >> 1), 17-bit intermediate.
  - Maximum result is 49152, so the value always fits in 16 bits unsigned. No saturation logic is required.
- Write rule: a beat with `cnt < NBINS` produces `we`=1, `waddr`=cnt, `wdata`=mag. Beats with `cnt ≥ NBINS` produce no write.
- Frame check, on an accepted `s_last` beat in RUN:
  - If `cnt == FRAME_LEN-1`, the frame is good and `frame_done` pulses.
  - Otherwise `frame_err` pulses, `peak_*` are not updated, and the state stays RUN. The counter resync described above applies.
  - If `s_last` is not seen at `cnt == FRAME_LEN-1`, `cnt` wraps to 0 and an internal overrun flag is set. That frame's `s_last` then reports `frame_err`. The flag clears at every `s_last`.
- Peak tracking:
  - The running max covers bins 1..NBINS-1. DC bin 0 is excluded.
  - Comparison is strict: on ties, the earliest bin wins.
  - The running max clears at each frame start.
  - `peak_bin` and `peak_mag` load in the same cycle as `frame_done` and hold until the next good frame.
- Reset mid-frame: the pipeline is flushed and no further `we` is issued. The state returns to SYNC, and the partial frame leaves stale RAM contents; this is acceptable.

## Timing

- Latency: a beat accepted in cycle N gives `we`/`waddr`/`wdata` registered outputs valid in cycle N+3.
- `frame_done` or `frame_err` for an `s_last` accepted in cycle N asserts in cycle N+3. This is the same cycle as the write for that beat, if one occurs.
- Throughput: one beat per cycle, sustained. Gaps in `s_valid` propagate as gaps in `we`.
- Reset values:
  - 0: `s_ready`, `we`, `frame_done`, `frame_err`, `peak_bin`, `peak_mag`, `cnt`.
  - 0: `waddr`, `wdata`.
  - State SYNC; all pipeline valid bits 0.
- `frame_done` and `frame_err` are never asserted in the same cycle.

## Test plan

- **Sync discard.**
  - Stimulus: release reset, then stream half a frame, then `s_last`, then a full 2048-beat frame with re=k, im=0.
  - Required: no `we` before the full frame. Then 1024 writes with `waddr`=k and `wdata`=k, each 3 cycles after its beat. `frame_done` 3 cycles after the last beat.
- **Magnitude corners.**
  - Stimulus: bins (re,im) = (-32768,-32768), (3,-4), (-5,0), (0,0).
  - Required: `wdata` = 49152, 5, 5, 0.
- **Peak.**
  - Stimulus: bin 0 = 40000-magnitude, bins 200 and 300 both magnitude 900, all others 10.
  - Required: `peak_bin`=200 and `peak_mag`=900, updating with `frame_done`.
- **Short frame.**
  - Stimulus: `s_last` at beat index 1500.
  - Required: `frame_err` pulse, no `frame_done`, `peak_*` unchanged. The next full frame reports `frame_done`.
- **Throttled input.**
  - Stimulus: random `s_valid` gaps across a full frame.
  - Required: exactly 1024 writes with addresses 0..1023 in order, data matching a reference model.
- **Reset mid-frame.**
  - Stimulus: assert `rst` at beat 600 for 2 cycles.
  - Required: `we` stops within 1 cycle and `s_ready`=0 during reset. The block re-enters SYNC and does not write until after the next `s_last`.
